// File: rtl/csc_layer_group_sched.sv
// Ping-pong register-group scheduler: tracks two config groups, launches and retires CSC layers in order.
// Optional run-cycle counters are built when CSC_GRP_PERF_CNT_EN is defined.
module csc_layer_group_sched #(
  parameter int unsigned LAUNCH_DLY = 2,
  parameter int unsigned CNT_W      = 4
) (
  input  logic        nvdla_core_clk,
  input  logic        nvdla_core_rstn,
  input  logic        op_en_wr,
  input  logic        op_en_grp,
  input  logic        dp_done,
  output logic        dp_start,
  output logic        dp_grp,
  output logic        consumer,
  output logic [1:0]  status_0,
  output logic [1:0]  status_1,
  output logic        op_en_0,
  output logic        op_en_1,
  output logic [1:0]  done_intr,
  output logic        err_wr_busy,
  output logic [31:0] perf_cyc_0,
  output logic [31:0] perf_cyc_1
);

  localparam logic [1:0] GRP_IDLE = 2'd0;
  localparam logic [1:0] GRP_RUN  = 2'd1;
  localparam logic [1:0] GRP_PEND = 2'd2;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RUN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             consumer_q, consumer_d;
  logic [1:0]       status_q [2];
  logic [1:0]       status_d [2];
  logic [1:0]       op_en_q, op_en_d;
  logic             start_q, start_d;
  logic [1:0]       done_q, done_d;
  logic             err_q, err_d;
  logic             other;

  assign other = ~consumer_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    consumer_d = consumer_q;
    status_d   = status_q;
    op_en_d    = op_en_q;
    start_d    = 1'b0;
    done_d     = 2'b00;
    err_d      = 1'b0;

    // Writes are judged on registered status, so a same-cycle done still rejects them.
    if (op_en_wr) begin
      if (status_q[op_en_grp] == GRP_IDLE) begin
        status_d[op_en_grp] = GRP_PEND;
        op_en_d[op_en_grp]  = 1'b1;
      end else if (status_q[op_en_grp] == GRP_RUN) begin
        err_d = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (status_q[consumer_q] == GRP_PEND) begin
          state_d = ST_WAIT;
          cnt_d   = CNT_W'(LAUNCH_DLY);
        end
      end
      ST_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          start_d              = 1'b1;
          status_d[consumer_q] = GRP_RUN;
          state_d              = ST_RUN;
        end
      end
      ST_RUN: begin
        if (dp_done) begin
          status_d[consumer_q] = GRP_IDLE;
          op_en_d[consumer_q]  = 1'b0;
          done_d[consumer_q]   = 1'b1;
          consumer_d           = other;
          // Skip the idle check when the other group is already queued to save a cycle.
          if (status_q[other] == GRP_PEND) begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(LAUNCH_DLY);
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      consumer_q  <= 1'b0;
      status_q[0] <= GRP_IDLE;
      status_q[1] <= GRP_IDLE;
      op_en_q     <= 2'b00;
      start_q     <= 1'b0;
      done_q      <= 2'b00;
      err_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      consumer_q <= consumer_d;
      status_q   <= status_d;
      op_en_q    <= op_en_d;
      start_q    <= start_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign dp_start    = start_q;
  assign dp_grp      = consumer_q;
  assign consumer    = consumer_q;
  assign status_0    = status_q[0];
  assign status_1    = status_q[1];
  assign op_en_0     = op_en_q[0];
  assign op_en_1     = op_en_q[1];
  assign done_intr   = done_q;
  assign err_wr_busy = err_q;

`ifdef CSC_GRP_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] run_cnt_q;
  logic [31:0] perf_q [2];

  // Latched value includes the done cycle itself.
  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      run_cnt_q <= '0;
      perf_q[0] <= '0;
      perf_q[1] <= '0;
    end else begin
      if (start_d) begin
        run_cnt_q <= '0;
      end else if (state_q == ST_RUN) begin
        run_cnt_q <= sat_inc(run_cnt_q);
      end
      if (state_q == ST_RUN && dp_done) begin
        perf_q[consumer_q] <= sat_inc(run_cnt_q);
      end
    end
  end

  assign perf_cyc_0 = perf_q[0];
  assign perf_cyc_1 = perf_q[1];
`else
  assign perf_cyc_0 = '0;
  assign perf_cyc_1 = '0;
`endif

endmodule
